// File: rtl/sap_memory_unit.sv
// SAP-1 memory stage: MAR, MDR and RAM, with a zero-latency read path onto the shared bus.
// Define PROG_LOADER_EN to add a streaming program loader that fills RAM while the CPU is held in reset.
module sap_memory_unit #(
  parameter int    ADDR_W    = 4,
  parameter int    DATA_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_addr_load_n,
  input  logic              mar_mem_load_n,
  input  logic              ram_en_n,
  input  logic              ram_load_n,
`ifdef PROG_LOADER_EN
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_full,
`endif
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  output logic [ADDR_W-1:0] mar_q,
  output logic              ctrl_err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              err_q;

  logic              ld_mar;
  logic              ld_mdr;
  logic              rd_en;
  logic              wr_en;
  logic              conflict;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Strobes are meaningless while the CPU is held in reset.
  assign ld_mar   = rst_n & ~mar_addr_load_n;
  assign ld_mdr   = rst_n & ~mar_mem_load_n;
  assign rd_en    = rst_n & ~ram_en_n;
  assign wr_en    = rst_n & ~ram_load_n;
  assign conflict = rd_en & (wr_en | ld_mar | ld_mdr);

  assign bus_drive = rd_en;
  assign bus_out   = rd_en ? mem[mar] : '0;
  assign mar_q     = mar;
  assign ctrl_err  = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mar   <= '0;
      mdr   <= '0;
      err_q <= 1'b0;
    end else begin
      if (ld_mar)   mar   <= bus_in[ADDR_W-1:0];
      if (ld_mdr)   mdr   <= bus_in;
      if (conflict) err_q <= 1'b1;
    end
  end

`ifdef PROG_LOADER_EN
  logic              was_running;
  logic              ptr_clear;
  logic              load_fire;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] load_addr;

  assign ptr_clear  = ~rst_n & was_running;
  assign prog_ready = ~rst_n & ~prog_full;
  assign load_fire  = prog_valid & prog_ready;
  // A byte accepted on the clearing edge lands at address 0, not the stale pointer.
  assign load_addr  = ptr_clear ? '0 : ptr;

  always_ff @(posedge clk) begin
    was_running <= rst_n;
    if (load_fire) begin
      ptr <= load_addr + 1'b1;
      if (load_addr == {ADDR_W{1'b1}}) prog_full <= 1'b1;
      else if (ptr_clear)              prog_full <= 1'b0;
    end else if (ptr_clear) begin
      ptr       <= '0;
      prog_full <= 1'b0;
    end
  end
`endif

  // Loader writes only in reset and the CPU path only out of reset, so they never collide.
  always_comb begin
    mem_we    = wr_en;
    mem_waddr = mar;
    mem_wdata = mdr;
`ifdef PROG_LOADER_EN
    if (load_fire) begin
      mem_we    = 1'b1;
      mem_waddr = load_addr;
      mem_wdata = prog_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule
